// File: rtl/apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// apu_frame_sequencer
//
// Purpose:
//   Frame sequencer for the square channels' low-rate housekeeping clocks.
//   A falling edge of the selected DIV bit (nominally 512 Hz) advances a
//   3-bit phase counter. The new phase value is decoded into one-cycle
//   strobes for the length counters, the frequency sweep and the volume
//   envelope. The phase bits also drive the 512/256/128 Hz level clocks.
//   The APU master enable holds the sequencer at phase 0 and blocks all
//   strobes.
//
// Configuration macro:
//   APU_DOUBLE_SPEED_EN - when defined, cgb_speed=1 selects div_bit5 so the
//                         tick rate stays at 512 Hz in CPU double-speed mode.
//                         When undefined, div_bit5 and cgb_speed are ignored
//                         and div_bit4 is always the tick source.
//
// Ports:
//   ajer_2mhz   in   APU clock; all state changes on its rising edge
//   napu_reset  in   asynchronous active-low reset
//   apu_en      in   APU master enable (NR52 bit 7)
//   div_bit4    in   DIV counter bit 4
//   div_bit5    in   DIV counter bit 5 (double-speed source)
//   cgb_speed   in   CPU double-speed flag
//   step        out  current sequencer phase 0..7
//   len_clk     out  one-cycle strobe, length counters
//   sweep_clk   out  one-cycle strobe, frequency sweep
//   env_clk     out  one-cycle strobe, volume envelope
//   horu_512hz  out  level clock, step[0]
//   bufy_256hz  out  level clock, step[1]
//   byfe_128hz  out  level clock, step[2]
//   len_skip    out  high when the next step will not clock length
// -----------------------------------------------------------------------------
module apu_frame_sequencer (
  input  logic       ajer_2mhz,
  input  logic       napu_reset,
  input  logic       apu_en,
  input  logic       div_bit4,
  input  logic       div_bit5,
  input  logic       cgb_speed,
  output logic [2:0] step,
  output logic       len_clk,
  output logic       sweep_clk,
  output logic       env_clk,
  output logic       horu_512hz,
  output logic       bufy_256hz,
  output logic       byfe_128hz,
  output logic       len_skip
);

  logic       divb;
  logic       div_q;
  logic       tick;
  logic [2:0] step_reg;
  logic [2:0] step_next;
  logic       len_clk_reg;
  logic       sweep_clk_reg;
  logic       env_clk_reg;

  // Tick source selection. A change of cgb_speed changes divb directly,
  // so a switch from a high to a low source bit is seen as a falling edge.
`ifdef APU_DOUBLE_SPEED_EN
  assign divb = cgb_speed ? div_bit5 : div_bit4;
`else
  assign divb = div_bit4;
  logic unused_speed_inputs;
  assign unused_speed_inputs = &{1'b0, div_bit5, cgb_speed};
`endif

  // div_q follows divb even while the APU is disabled, so enabling with
  // divb already low cannot manufacture a falling edge. A DIV write that
  // clears a set bit is an ordinary falling edge and ticks.
  assign tick      = div_q & ~divb;
  assign step_next = step_reg + 3'd1;

  always_ff @(posedge ajer_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      div_q         <= 1'b0;
      step_reg      <= 3'd0;
      len_clk_reg   <= 1'b0;
      sweep_clk_reg <= 1'b0;
      env_clk_reg   <= 1'b0;
    end else begin
      div_q <= divb;
      if (!apu_en) begin
        // Disable wins over a coincident tick: phase 0, no strobe.
        step_reg      <= 3'd0;
        len_clk_reg   <= 1'b0;
        sweep_clk_reg <= 1'b0;
        env_clk_reg   <= 1'b0;
      end else if (tick) begin
        // Strobes decode the phase being entered, not the one being left.
        step_reg      <= step_next;
        len_clk_reg   <= ~step_next[0];
        sweep_clk_reg <= step_next[1] & ~step_next[0];
        env_clk_reg   <= &step_next;
      end else begin
        len_clk_reg   <= 1'b0;
        sweep_clk_reg <= 1'b0;
        env_clk_reg   <= 1'b0;
      end
    end
  end

  assign step      = step_reg;
  assign len_clk   = len_clk_reg;
  assign sweep_clk = sweep_clk_reg;
  assign env_clk   = env_clk_reg;

  // Level clocks come straight from register bits, so they cannot glitch.
  assign horu_512hz = step_reg[0];
  assign bufy_256hz = step_reg[1];
  assign byfe_128hz = step_reg[2];
  assign len_skip   = ~step_reg[0];

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame sequencer that schedules the low-rate housekeeping clocks for the square channels: length counter, frequency sweep and volume envelope. It detects falling edges of the selected DIV counter bit (512 Hz nominal) and steps a 3-bit phase counter. From that counter it drives one-cycle strobes plus the 512/256/128 Hz level clocks consumed by channel 1. It sits between the DIV register and the channel blocks and is gated by the APU master enable.

## Interface
Parameters:
- none

Ports:
- ajer_2mhz  input  1  APU clock; all state updates on its rising edge
- napu_reset  input  1  reset, asynchronous and active-low
- apu_en  input  1  APU master enable (NR52 bit 7), synchronous to ajer_2mhz
- div_bit4  input  1  DIV counter bit 4, synchronous to ajer_2mhz
- div_bit5  input  1  DIV counter bit 5; used only with APU_DOUBLE_SPEED_EN
- cgb_speed  input  1  CPU double-speed flag; used only with APU_DOUBLE_SPEED_EN
- step  output  3  current sequencer phase 0..7
- len_clk  output  1  one-cycle strobe, length counters
- sweep_clk  output  1  one-cycle strobe, frequency sweep
- env_clk  output  1  one-cycle strobe, volume envelope
- horu_512hz  output  1  level clock, equals step[0]
- bufy_256hz  output  1  level clock, equals step[1]
- byfe_128hz  output  1  level clock, equals step[2]
- len_skip  output  1  high when the next step will not clock length (step[0]==0)

## Operation
- Selected bit divb = div_bit4; with the macro and cgb_speed=1, divb = div_bit5.
- Register div_q samples divb on every edge, regardless of apu_en.
- Tick: div_q==1 and divb==0 at an edge with apu_en==1.
- On a tick: step <= step+1 (mod 8, 7 wraps to 0). Strobes are decoded from the new step value:
  - len_clk: new step ∈ {0,2,4,6}
  - sweep_clk: new step ∈ {2,6}
  - env_clk: new step == 7
- Strobes are registered and low on every edge without a tick.
- apu_en==0: step held at 0 and all strobes forced low. div_q keeps tracking, so enabling while divb is low produces no spurious tick.
- An external DIV write that clears a set divb is a falling edge and produces a tick. This is required behaviour.
- apu_en falling mid-sequence: step is 0 on the next edge and no strobe is emitted on that edge.
- Level clocks and len_skip are combinational from step, so they are glitch-free (registered source).

## Timing
- Reset values: step=0, div_q=0, len_clk=sweep_clk=env_clk=0, horu_512hz=bufy_256hz=byfe_128hz=0, len_skip=1.
- Latency: the strobe is high for exactly the one cycle following the edge that samples divb falling. step updates on that same edge.
- Minimum tick spacing is two edges (divb must be re-seen high). Back-to-back ticks are impossible.
- Tick coincident with apu_en falling: apu_en wins, so step=0 and there is no strobe.
- Reset deassertion while divb=1: the first sampled 0 after div_q loads 1 is the first tick. There is no tick directly out of reset, because div_q resets to 0.
- Full cycle: 8 ticks, giving 4 len, 2 sweep and 1 env strobes.

## Configuration
- APU_DOUBLE_SPEED_EN defined: the cgb_speed port selects div_bit5 when high, keeping 512 Hz in double-speed mode. A change of cgb_speed is treated as a change of divb and may tick.
- APU_DOUBLE_SPEED_EN undefined: div_bit5 and cgb_speed are present but ignored, and divb is always div_bit4.

## Test plan
- Reset, apu_en=1, then toggle div_bit4 1→0 eight times → step 1,2,...,7,0; len_clk on steps 2,4,6,0; sweep_clk on 2,6; env_clk on 7; each strobe 1 cycle wide.
- Hold apu_en=0 while toggling div_bit4 → step stays 0 and there are no strobes. Raise apu_en with div_bit4=0 → no tick until the next 1→0.
- At step 5, drop apu_en on the same edge as a div_bit4 fall → step=0, no strobe. Re-enable and tick once → step=1, len_skip=0.
- DIV write forcing div_bit4 from 1 to 0 at step 3 → step=4, len_clk=1 for one cycle, byfe_128hz=1, bufy_256hz=0.
- Assert napu_reset low asynchronously mid-cycle at step 6 → all outputs reset immediately with no clock edge; len_skip=1.
- With APU_DOUBLE_SPEED_EN and cgb_speed=1, toggle only div_bit4 → no ticks. Toggle div_bit5 1→0 → step increments.
